uart_fifo_sched: RTL and testbench
==================================

Name: uart_fifo_sched

Overview:
- Controller that sequences the multi-byte UART FIFO in the wishbone UART slave.
- Write side: packs host words of 1–4 bytes into single FIFO write strobes. Admits a word only when enough space is tracked, so the FIFO never overflows.
- Read side: drains the FIFO one byte at a time into the UART transmitter's valid/ready byte port, with CTS flow control and an optional inter-byte gap.
- Keeps its own authoritative fill level and sticky error flags for the register file.

Parameters:
- DEPTH_LOG2, 8, log2 of FIFO storage. Usable capacity CAP = 2^DEPTH_LOG2 − 1, since the ring keeps one slot empty.
- GAP_CYCLES, 0, idle clocks inserted after each transmitted byte.
- GAP_W, 16, width of the gap counter; GAP_CYCLES < 2^GAP_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- host_valid  in  1  host word offered
- host_data  in  32  byte0 = [7:0] … byte3 = [31:24]
- host_count  in  3  bytes in word, legal range 1..4
- host_ready  out  1  word accepted this cycle (combinational)
- fifo_write_strobe  out  1  one-cycle FIFO write
- fifo_write_strobe_count  out  4  bytes written, 1..4
- fifo_write_data0..3  out  8 each  bytes to FIFO
- fifo_read_strobe  out  1  pop one byte
- fifo_read_data  in  8  FIFO head byte, combinational from the FIFO
- fifo_empty  in  1  FIFO empty flag
- tx_valid  out  1  byte presented to transmitter
- tx_byte  out  8  byte to transmit
- tx_ready  in  1  transmitter takes byte
- cts_n  in  1  active-low clear-to-send
- level  out  DEPTH_LOG2+1  committed bytes in FIFO
- status_clear  in  1  clears sticky errors
- err_bad_count  out  1  sticky: host_valid seen with host_count 0 or >4
- err_underflow  out  1  sticky: fifo_empty seen while level ≠ 0

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n).
  - On reset, all outputs go to 0, the read FSM goes to IDLE, and level = 0. tx_valid drops immediately.
  - A transfer in flight mid-reset is discarded. Nothing is replayed.
- Write admission:
  - host_ready = host_valid && host_count in 1..4 && (CAP − level) ≥ host_count.
  - Accept on the edge where host_valid && host_ready. Data and count are registered at that edge.
  - fifo_write_strobe is high for exactly the next cycle, carrying the registered data and count. Latency is 1.
  - Back-to-back accepts are allowed every cycle.
  - No partial writes: a word that does not fit stalls whole until space frees.
  - Illegal count: host_ready = 0, err_bad_count set, and the word is never accepted. The host must withdraw it.
- Level arithmetic:
  - Next level = level + (accept ? host_count : 0) − (pop ? 1 : 0).
  - Simultaneous accept and pop net out in the same edge.
  - Space check uses the pre-pop level. This is conservative and never exceeds CAP.
  - level never wraps. An error path that would go negative forces level to 0.
- Read FSM:
  - IDLE: if level ≠ 0 and cts_n = 0, go to FETCH.
  - IDLE is at least one cycle, which guarantees a write strobe has landed before its byte is fetched.
  - FETCH, case fifo_empty = 0:
    - fifo_read_strobe = 1 for one cycle and level decrements.
    - tx_byte is captured from fifo_read_data at the same edge.
    - Go to SEND.
  - FETCH, case fifo_empty = 1:
    - No strobe is issued; err_underflow is set and level is forced to 0.
    - Go to IDLE.
  - SEND: tx_valid = 1 and tx_byte is held stable until tx_ready.
    - On the handshake edge, go to GAP if GAP_CYCLES > 0, else IDLE.
    - cts_n rising during SEND does not abort the byte.
  - GAP: load the counter with GAP_CYCLES on entry and decrement each clock. At 0, go to IDLE.
  - Throughput with GAP_CYCLES = 0 and tx_ready tied high: one byte per 3 clocks (IDLE, FETCH, SEND).
- Errors:
  - Flags are sticky until status_clear = 1.
  - A set condition in the same cycle as status_clear wins, so the flag stays 1.

Decomposition:
- Package uart_fifo_sched_pkg holds:
  - read FSM state encoding (IDLE, FETCH, SEND, GAP);
  - MAX_BURST = 4;
  - a function computing CAP from DEPTH_LOG2.
- One sub-module, uart_fifo_drain, contains the read FSM, gap counter and tx handshake.
  - Its outputs are pop and underflow_evt.
  - The top level owns admission, the level counter and the error flags.

Test Plan:
- Reset with cts_n = 0. Offer host_data = 0x44332211, count 4 → one fifo_write_strobe with count 4 and data0..3 = 11, 22, 33, 44. Level goes 0→4. tx sees bytes 11, 22, 33, 44 in order. Level returns to 0 and host_ready is high again.
- DEPTH_LOG2 = 3 (CAP = 7), cts_n = 1. Write count 4, then count 4 → second word stalls with host_ready = 0. Then count 3 → accepted, level = 7. Assert cts_n = 0 → after the first pop, the stalled count-4 word stays blocked until level ≤ 3.
- Hold tx_ready = 0 for 10 cycles in SEND → tx_valid and tx_byte stay stable and no extra read strobe is issued. Set GAP_CYCLES = 5 → exactly 5 idle cycles between tx handshakes.
- Accept a count-2 word in the same cycle as a pop at level 3 → level = 4. Offer host_count = 0 → err_bad_count = 1, which persists until status_clear.
- Force fifo_empty = 1 while level = 2 → err_underflow = 1, level = 0, no read strobe. Assert rst_n = 0 mid-SEND → tx_valid = 0 immediately, level = 0, FSM in IDLE.

Source files
------------

// File: rtl/uart_fifo_sched_pkg.sv
// Shared types and constants for the UART FIFO scheduler.
// Holds the drain FSM state encoding, the largest host word size and the FIFO capacity helper.
package uart_fifo_sched_pkg;

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StGap} rd_state_e;

    localparam int unsigned MAX_BURST = 4;

    // The ring keeps one slot empty, so usable capacity is one less than storage.
    function automatic int unsigned fifo_cap(input int unsigned depth_log2);
        return (1 << depth_log2) - 1;
    endfunction

endpackage

// File: rtl/uart_fifo_drain.sv
// Read side of the scheduler: pops one FIFO byte at a time into the transmitter
// valid/ready port, honouring CTS and an optional inter-byte gap.
module uart_fifo_drain import uart_fifo_sched_pkg::*; #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned GAP_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level_nz,
    input  logic       cts_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_read_data,
    input  logic       tx_ready,
    output logic       pop,
    output logic       underflow_evt,
    output logic       tx_valid,
    output logic [7:0] tx_byte
);

    rd_state_e        state_q;
    logic [GAP_W-1:0] gap_q;

    // The FIFO head is only known in FETCH, so the strobe decision is combinational there.
    assign pop           = (state_q == StFetch) && !fifo_empty;
    assign underflow_evt = (state_q == StFetch) && fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (level_nz && !cts_n) state_q <= StFetch;
                end
                StFetch: begin
                    if (fifo_empty) begin
                        state_q <= StIdle;
                    end else begin
                        tx_byte  <= fifo_read_data;
                        tx_valid <= 1'b1;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (GAP_CYCLES != 0) begin
                            gap_q   <= GAP_W'(GAP_CYCLES);
                            state_q <= StGap;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StGap: begin
                    gap_q <= gap_q - 1'b1;
                    if (gap_q == GAP_W'(1)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_sched.sv
// Multi-byte UART FIFO scheduler: admits 1-4 byte host words into the FIFO without overflow,
// drains bytes to the transmitter, and keeps the committed fill level plus sticky errors.
module uart_fifo_sched import uart_fifo_sched_pkg::*; #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned GAP_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_valid,
    input  logic [31:0]           host_data,
    input  logic [2:0]            host_count,
    output logic                  host_ready,
    output logic                  fifo_write_strobe,
    output logic [3:0]            fifo_write_strobe_count,
    output logic [7:0]            fifo_write_data0,
    output logic [7:0]            fifo_write_data1,
    output logic [7:0]            fifo_write_data2,
    output logic [7:0]            fifo_write_data3,
    output logic                  fifo_read_strobe,
    input  logic [7:0]            fifo_read_data,
    input  logic                  fifo_empty,
    output logic                  tx_valid,
    output logic [7:0]            tx_byte,
    input  logic                  tx_ready,
    input  logic                  cts_n,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  status_clear,
    output logic                  err_bad_count,
    output logic                  err_underflow
);

    localparam int unsigned LW  = DEPTH_LOG2 + 1;
    localparam int unsigned CAP = fifo_cap(DEPTH_LOG2);

    logic          count_ok;
    logic          accept;
    logic          pop;
    logic          underflow_evt;
    logic [LW-1:0] space;
    logic [LW-1:0] level_base;
    logic [LW-1:0] level_d;

    assign count_ok   = (host_count != 3'd0) && (host_count <= 3'(MAX_BURST));
    // Space is judged on the pre-pop level, so a same-cycle pop never lets level exceed CAP.
    assign space      = LW'(CAP) - level;
    assign host_ready = host_valid && count_ok && (space >= LW'(host_count));
    assign accept     = host_ready;

    assign fifo_read_strobe = pop;

    always_comb begin
        level_base = underflow_evt ? '0 : level;
        level_d    = level_base + (accept ? LW'(host_count) : '0);
        if (pop) level_d = (level_d == '0) ? '0 : level_d - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level                   <= '0;
            fifo_write_strobe       <= 1'b0;
            fifo_write_strobe_count <= '0;
            fifo_write_data0        <= '0;
            fifo_write_data1        <= '0;
            fifo_write_data2        <= '0;
            fifo_write_data3        <= '0;
            err_bad_count           <= 1'b0;
            err_underflow           <= 1'b0;
        end else begin
            level             <= level_d;
            fifo_write_strobe <= accept;
            if (accept) begin
                fifo_write_strobe_count <= {1'b0, host_count};
                fifo_write_data0        <= host_data[7:0];
                fifo_write_data1        <= host_data[15:8];
                fifo_write_data2        <= host_data[23:16];
                fifo_write_data3        <= host_data[31:24];
            end
            // A new error in the clearing cycle keeps the flag set.
            err_bad_count <= (host_valid && !count_ok) || (err_bad_count && !status_clear);
            err_underflow <= underflow_evt || (err_underflow && !status_clear);
        end
    end

    uart_fifo_drain #(
        .GAP_CYCLES(GAP_CYCLES),
        .GAP_W     (GAP_W)
    ) u_drain (
        .clk           (clk),
        .rst_n         (rst_n),
        .level_nz      (level != '0),
        .cts_n         (cts_n),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .tx_ready      (tx_ready),
        .pop           (pop),
        .underflow_evt (underflow_evt),
        .tx_valid      (tx_valid),
        .tx_byte       (tx_byte)
    );

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Bench for uart_fifo_sched: directed scenarios plus random traffic against a byte-stream
// reference model; a second instance with a 5-cycle gap checks inter-byte spacing.
module tb_uart_fifo_sched;

    localparam int unsigned DL  = 3;
    localparam int          CAP = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: no gap
    logic        host_valid   = 1'b0;
    logic [31:0] host_data    = '0;
    logic [2:0]  host_count   = '0;
    logic        tx_ready     = 1'b0;
    logic        cts_n        = 1'b1;
    logic        status_clear = 1'b0;
    logic        force_empty  = 1'b0;
    logic        host_ready, fws, frs, fempty, tx_valid, err_bad, err_under;
    logic [3:0]  fwc;
    logic [7:0]  fwd0, fwd1, fwd2, fwd3, frd, tx_byte;
    logic [DL:0] level;

    // Instance B: 5-cycle gap, CTS asserted, transmitter always ready
    logic        hb_valid = 1'b0;
    logic [31:0] hb_data  = '0;
    logic [2:0]  hb_count = '0;
    logic        host_ready_b, fws_b, frs_b, fempty_b, tx_valid_b, err_bad_b, err_under_b;
    logic [3:0]  fwc_b;
    logic [7:0]  fwb0, fwb1, fwb2, fwb3, frd_b, tx_byte_b;
    logic [DL:0] level_b;

    uart_fifo_sched #(.DEPTH_LOG2(DL), .GAP_CYCLES(0), .GAP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_data(host_data),
        .host_count(host_count), .host_ready(host_ready), .fifo_write_strobe(fws),
        .fifo_write_strobe_count(fwc), .fifo_write_data0(fwd0), .fifo_write_data1(fwd1),
        .fifo_write_data2(fwd2), .fifo_write_data3(fwd3), .fifo_read_strobe(frs),
        .fifo_read_data(frd), .fifo_empty(fempty), .tx_valid(tx_valid), .tx_byte(tx_byte),
        .tx_ready(tx_ready), .cts_n(cts_n), .level(level), .status_clear(status_clear),
        .err_bad_count(err_bad), .err_underflow(err_under)
    );

    uart_fifo_sched #(.DEPTH_LOG2(DL), .GAP_CYCLES(5), .GAP_W(16)) dut_gap (
        .clk(clk), .rst_n(rst_n), .host_valid(hb_valid), .host_data(hb_data),
        .host_count(hb_count), .host_ready(host_ready_b), .fifo_write_strobe(fws_b),
        .fifo_write_strobe_count(fwc_b), .fifo_write_data0(fwb0), .fifo_write_data1(fwb1),
        .fifo_write_data2(fwb2), .fifo_write_data3(fwb3), .fifo_read_strobe(frs_b),
        .fifo_read_data(frd_b), .fifo_empty(fempty_b), .tx_valid(tx_valid_b),
        .tx_byte(tx_byte_b), .tx_ready(1'b1), .cts_n(1'b0), .level(level_b),
        .status_clear(1'b0), .err_bad_count(err_bad_b), .err_underflow(err_under_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte FIFO models standing in for the real FIFOs; head/empty update after the edge.
    byte unsigned fq_a[$];
    byte unsigned fq_b[$];
    logic [7:0]   head_a  = '0, head_b = '0;
    logic         empty_a = 1'b1, empty_b = 1'b1;
    logic [31:0]  wa, wb;
    assign frd      = head_a;
    assign fempty   = empty_a | force_empty;
    assign frd_b    = head_b;
    assign fempty_b = empty_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq_a.delete();
            fq_b.delete();
        end else begin
            if (frs && fq_a.size() > 0) void'(fq_a.pop_front());
            if (frs_b && fq_b.size() > 0) void'(fq_b.pop_front());
            wa = {fwd3, fwd2, fwd1, fwd0};
            wb = {fwb3, fwb2, fwb1, fwb0};
            if (fws) for (int i = 0; i < int'(fwc); i++) fq_a.push_back(wa[8*i +: 8]);
            if (fws_b) for (int i = 0; i < int'(fwc_b); i++) fq_b.push_back(wb[8*i +: 8]);
        end
        head_a  <= (fq_a.size() > 0) ? fq_a[0] : 8'h00;
        empty_a <= (fq_a.size() == 0);
        head_b  <= (fq_b.size() > 0) ? fq_b[0] : 8'h00;
        empty_b <= (fq_b.size() == 0);
    end

    // Reference model for instance A: committed level, expected byte stream, write strobes.
    int           m_level = 0;
    byte unsigned exp_q[$];
    bit           wr_pend = 1'b0;
    int           pend_cnt = 0;
    logic [31:0]  pend_data = '0;
    bit           m_bad = 1'b0;
    bit           mon_en = 1'b1;
    bit           exp_rdy;
    int           hc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_level = 0;
            exp_q.delete();
            wr_pend = 1'b0;
            m_bad   = 1'b0;
        end else if (mon_en) begin
            hc      = int'(host_count);
            exp_rdy = host_valid && hc >= 1 && hc <= 4 && (CAP - m_level) >= hc;
            chk("level", 32'(level), m_level);
            chk("host_ready", 32'(host_ready), 32'(exp_rdy));
            chk("wr_strobe", 32'(fws), 32'(wr_pend));
            if (wr_pend) begin
                chk("wr_count", 32'(fwc), pend_cnt);
                chk("wr_data", {fwd3, fwd2, fwd1, fwd0}, pend_data);
            end
            chk("err_bad_count", 32'(err_bad), 32'(m_bad));
            chk("err_underflow", 32'(err_under), 32'(0));
            if (frs) chk("pop_on_empty", 32'(fempty), 32'(0));
            if (tx_valid && tx_ready) begin
                chk("tx_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
            end
            wr_pend   = exp_rdy;
            pend_cnt  = hc;
            pend_data = host_data;
            if (exp_rdy) for (int i = 0; i < hc; i++) exp_q.push_back(host_data[8*i +: 8]);
            m_level = m_level + (exp_rdy ? hc : 0) - (frs ? 1 : 0);
            if (host_valid && (hc < 1 || hc > 4)) m_bad = 1'b1;
            else if (status_clear) m_bad = 1'b0;
        end
    end

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_level == 0 && exp_q.size() == 0 && !tx_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(done), 32'(1));
    endtask

    task automatic wait_txv(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tx_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(got), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          hs_t[4];
    logic [7:0]  hs_b[4];
    int          n;
    int          acc_lvl;
    bit          done;
    logic [7:0]  b0;
    logic [31:0] hd;
    int          r;

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_tx_byte", 32'(tx_byte), 32'(0));
        chk("rst_wstrobe", {27'd0, fws, fwc}, 32'(0));
        chk("rst_rstrobe", 32'(frs), 32'(0));
        chk("rst_errs", {30'd0, err_bad, err_under}, 32'(0));
        chk("rst_ready", 32'(host_ready), 32'(0));
        rst_n = 1'b1;

        // Single 4-byte word, full drain at one byte per 3 clocks
        cts_n      = 1'b0;
        tx_ready   = 1'b1;
        host_valid = 1'b1;
        host_data  = 32'h4433_2211;
        host_count = 3'd4;
        #1 chk("t1_ready", 32'(host_ready), 32'(1));
        tick();
        host_valid = 1'b0;
        chk("t1_level", 32'(level), 32'(4));
        chk("t1_wstrobe", 32'(fws), 32'(1));
        chk("t1_wcount", 32'(fwc), 32'(4));
        chk("t1_wdata", {fwd3, fwd2, fwd1, fwd0}, 32'h4433_2211);
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            if (tx_valid && tx_ready) begin
                hs_t[n] = cyc;
                hs_b[n] = tx_byte;
                n++;
            end
            tick();
        end
        chk("t1_nbytes", n, 4);
        for (int i = 0; i < 4 && i < n; i++) chk("t1_byte_order", 32'(hs_b[i]), 32'(8'h11 * (i + 1)));
        for (int i = 1; i < 4 && i < n; i++) chk("t1_spacing", hs_t[i] - hs_t[i-1], 3);
        wait_drain("t1_drain");
        chk("t1_level_zero", 32'(level), 32'(0));
        host_valid = 1'b1;
        host_count = 3'd4;
        #1 chk("t1_ready_again", 32'(host_ready), 32'(1));
        host_valid = 1'b0;
        tick();

        // Capacity stall with CTS deasserted, then admission once level drops to 3
        cts_n      = 1'b1;
        host_valid = 1'b1;
        host_data  = $urandom;
        host_count = 3'd4;
        tick();
        chk("t2_level4", 32'(level), 32'(4));
        host_data = $urandom;
        #1 chk("t2_stall", 32'(host_ready), 32'(0));
        tick();
        chk("t2_stall_hold", 32'(host_ready), 32'(0));
        host_count = 3'd3;
        #1 chk("t2_fit3", 32'(host_ready), 32'(1));
        tick();
        chk("t2_level7", 32'(level), 32'(7));
        host_count = 3'd4;
        host_data  = $urandom;
        cts_n      = 1'b0;
        acc_lvl    = -1;
        done       = 1'b0;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            #1;
            if (host_ready) begin
                acc_lvl = int'(level);
                done    = 1'b1;
            end
            tick();
        end
        host_valid = 1'b0;
        chk("t2_admit_level", acc_lvl, 3);
        wait_drain("t2_drain");

        // Transmitter back-pressure: byte held, no extra pops
        tx_ready   = 1'b0;
        host_valid = 1'b1;
        hd         = $urandom;
        host_data  = hd;
        host_count = 3'd2;
        tick();
        host_valid = 1'b0;
        wait_txv("t3_valid_seen");
        b0 = tx_byte;
        chk("t3_first_byte", 32'(b0), 32'(hd[7:0]));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_valid", 32'(tx_valid), 32'(1));
            chk("t3_hold_byte", 32'(tx_byte), 32'(b0));
            chk("t3_no_pop", 32'(frs), 32'(0));
        end
        chk("t3_level", 32'(level), 32'(1));
        tx_ready = 1'b1;
        wait_drain("t3_drain");

        // Accept and pop on the same edge at level 3
        cts_n      = 1'b1;
        host_valid = 1'b1;
        host_data  = $urandom;
        host_count = 3'd3;
        tick();
        host_valid = 1'b0;
        chk("t4_level3", 32'(level), 32'(3));
        tick();
        cts_n = 1'b0;
        tick();
        chk("t4_pop_now", 32'(frs), 32'(1));
        host_valid = 1'b1;
        host_data  = $urandom;
        host_count = 3'd2;
        #1 chk("t4_ready", 32'(host_ready), 32'(1));
        tick();
        host_valid = 1'b0;
        chk("t4_level_net", 32'(level), 32'(4));
        wait_drain("t4_drain");

        // Illegal counts and sticky clearing
        host_valid = 1'b1;
        host_count = 3'd0;
        #1 chk("bad_ready", 32'(host_ready), 32'(0));
        tick();
        host_valid = 1'b0;
        chk("bad_set", 32'(err_bad), 32'(1));
        repeat (3) tick();
        chk("bad_sticky", 32'(err_bad), 32'(1));
        host_valid   = 1'b1;
        host_count   = 3'd5;
        status_clear = 1'b1;
        #1 chk("bad5_ready", 32'(host_ready), 32'(0));
        tick();
        host_valid = 1'b0;
        chk("bad_set_beats_clear", 32'(err_bad), 32'(1));
        tick();
        status_clear = 1'b0;
        chk("bad_cleared", 32'(err_bad), 32'(0));

        // FIFO reports empty while level is 2
        cts_n      = 1'b1;
        host_valid = 1'b1;
        host_data  = $urandom;
        host_count = 3'd2;
        tick();
        host_valid = 1'b0;
        tick();
        mon_en      = 1'b0;
        force_empty = 1'b1;
        cts_n       = 1'b0;
        tick();
        chk("uf_no_pop", 32'(frs), 32'(0));
        tick();
        chk("uf_flag", 32'(err_under), 32'(1));
        chk("uf_level", 32'(level), 32'(0));
        chk("uf_no_valid", 32'(tx_valid), 32'(0));
        force_empty = 1'b0;
        cts_n       = 1'b1;
        rst_n       = 1'b0;
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reset asserted while a byte is waiting in SEND
        cts_n      = 1'b0;
        tx_ready   = 1'b0;
        host_valid = 1'b1;
        host_data  = $urandom;
        host_count = 3'd3;
        tick();
        host_valid = 1'b0;
        wait_txv("rs_in_send");
        rst_n = 1'b0;
        #1;
        chk("rs_tx_valid", 32'(tx_valid), 32'(0));
        chk("rs_level", 32'(level), 32'(0));
        chk("rs_err", 32'(err_under), 32'(0));
        tick();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_idle_valid", 32'(tx_valid), 32'(0));
            chk("rs_idle_pop", 32'(frs), 32'(0));
        end

        // Random traffic against the reference model
        for (int cyc = 0; cyc < 600; cyc++) begin
            host_valid   = ($urandom_range(0, 2) != 0);
            r            = int'($urandom_range(0, 19));
            host_count   = (r == 0) ? 3'd0 : (r == 1) ? 3'd5 : 3'($urandom_range(1, 4));
            host_data    = $urandom;
            cts_n        = ($urandom_range(0, 5) == 0);
            tx_ready     = $urandom_range(0, 1) != 0;
            status_clear = ($urandom_range(0, 15) == 0);
            tick();
        end
        host_valid   = 1'b0;
        status_clear = 1'b0;
        cts_n        = 1'b0;
        tx_ready     = 1'b1;
        wait_drain("rand_drain");

        // Gap instance: GAP adds exactly 5 clocks to the 3-clock byte period
        hb_valid = 1'b1;
        hb_data  = 32'hD4C3_B2A1;
        hb_count = 3'd4;
        #1 chk("g_ready", 32'(host_ready_b), 32'(1));
        tick();
        hb_valid = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
            if (tx_valid_b) begin
                hs_t[n] = cyc;
                hs_b[n] = tx_byte_b;
                n++;
            end
            tick();
        end
        chk("g_nbytes", n, 4);
        for (int i = 0; i < 4 && i < n; i++) chk("g_byte", 32'(hs_b[i]), 32'(8'hA1 + 8'h11 * i));
        for (int i = 1; i < 4 && i < n; i++) chk("g_spacing", hs_t[i] - hs_t[i-1], 8);
        repeat (8) tick();
        chk("g_level", 32'(level_b), 32'(0));
        chk("g_errs", {30'd0, err_bad_b, err_under_b}, 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
